bf_program_mem: RTL and testbench

- Parametrised, loadable program memory for the brainfuck core. Replaces the fixed hard-coded program ROM.
- A byte-stream loader writes the program at run time, for example from the UART receiver. Non-command characters are dropped, bracket nesting is checked and a 0x00 terminator is appended.
- The processor reads instructions through a registered read port with 1-cycle latency.

---
 rtl/bf_program_mem.sv | 126 ++++++++++++
 tb/tb_bf_program_mem.sv | 264 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/bf_program_mem.sv
// Loadable program memory for the brainfuck core: filters a byte stream down to
// command characters, tracks bracket nesting, appends a 0x00 terminator.
module bf_program_mem #(
   parameter int ADDR_WIDTH = 8,
   parameter int NEST_WIDTH = 6
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  loadStart,
   input  logic                  loadValid,
   input  logic [7:0]            loadData,
   output logic                  loadReady,
   input  logic                  loadEnd,
   input  logic [ADDR_WIDTH-1:0] addrIn,
   output logic [7:0]            dataOut,
   output logic [ADDR_WIDTH:0]   progLen,
   output logic                  progReady,
   output logic                  errOverflow,
   output logic                  errUnbalanced
);
   localparam int DEPTH = 1 << ADDR_WIDTH;
   localparam logic [ADDR_WIDTH:0] MAX_LEN = {1'b0, {ADDR_WIDTH{1'b1}}};

   typedef enum logic [1:0] {IDLE, LOAD, FINISH, RUN} state_t;

   state_t                state;
   logic [7:0]            mem [DEPTH];
   logic [NEST_WIDTH-1:0] nest;
   logic                  xfer;
   logic                  isCmd;
   logic                  hasRoom;
   logic                  wrEn;
   logic [7:0]            wrData;

   // loadReady is high exactly while in LOAD, so it doubles as the transfer qualifier.
   assign xfer    = loadValid && loadReady;
   assign hasRoom = progLen < MAX_LEN;

   always_comb begin
      case (loadData)
         8'h2B, 8'h2D, 8'h3C, 8'h3E, 8'h2E, 8'h2C, 8'h5B, 8'h5D: isCmd = 1'b1;
         default: isCmd = 1'b0;
      endcase
   end

   always_comb begin
      wrEn   = 1'b0;
      wrData = loadData;
      if (!loadStart) begin
         if (state == LOAD && xfer && isCmd && hasRoom)
            wrEn = 1'b1;
         if (state == FINISH) begin
            wrEn   = 1'b1;
            wrData = '0;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (wrEn)
         mem[progLen[ADDR_WIDTH-1:0]] <= wrData;
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state         <= IDLE;
         dataOut       <= '0;
         progLen       <= '0;
         progReady     <= 1'b0;
         loadReady     <= 1'b0;
         errOverflow   <= 1'b0;
         errUnbalanced <= 1'b0;
         nest          <= '0;
      end else begin
         // Reads outside RUN or past the terminator return 0x00 so stale bytes never leak.
         if (state == RUN && {1'b0, addrIn} <= progLen)
            dataOut <= mem[addrIn];
         else
            dataOut <= '0;

         if (loadStart) begin
            state         <= LOAD;
            loadReady     <= 1'b1;
            progReady     <= 1'b0;
            progLen       <= '0;
            nest          <= '0;
            errOverflow   <= 1'b0;
            errUnbalanced <= 1'b0;
         end else begin
            case (state)
               LOAD: begin
                  if (xfer && isCmd) begin
                     if (hasRoom)
                        progLen <= progLen + (ADDR_WIDTH+1)'(1);
                     else
                        errOverflow <= 1'b1;
                     if (loadData == 8'h5B) begin
                        if (nest == '1)
                           errUnbalanced <= 1'b1;
                        else
                           nest <= nest + NEST_WIDTH'(1);
                     end else if (loadData == 8'h5D) begin
                        if (nest == '0)
                           errUnbalanced <= 1'b1;
                        else
                           nest <= nest - NEST_WIDTH'(1);
                     end
                  end
                  if (loadEnd) begin
                     state     <= FINISH;
                     loadReady <= 1'b0;
                  end
               end
               FINISH: begin
                  if (nest != '0)
                     errUnbalanced <= 1'b1;
                  state     <= RUN;
                  progReady <= 1'b1;
               end
               IDLE, RUN: ;
               default: state <= IDLE;
            endcase
         end
      end
   end
endmodule

// File: tb/tb_bf_program_mem.sv
// Bench for bf_program_mem: two instances (ADDR_WIDTH 8 and 4) share stimulus and
// are compared every cycle against a transaction-level program model.
module tb_bf_program_mem;
   logic       clk = 1'b0;
   logic       reset;
   logic       loadStart, loadValid, loadEnd;
   logic [7:0] loadData, addrIn;

   logic       loadReadyA, progReadyA, errOverflowA, errUnbalancedA;
   logic [7:0] dataOutA;
   logic [8:0] progLenA;
   logic       loadReadyB, progReadyB, errOverflowB, errUnbalancedB;
   logic [7:0] dataOutB;
   logic [4:0] progLenB;

   int nChecks = 0;
   int nErrors = 0;

   always #5 clk = ~clk;

   bf_program_mem #(.ADDR_WIDTH(8), .NEST_WIDTH(6)) dutA (
      .clk(clk), .reset(reset), .loadStart(loadStart), .loadValid(loadValid),
      .loadData(loadData), .loadReady(loadReadyA), .loadEnd(loadEnd),
      .addrIn(addrIn), .dataOut(dataOutA), .progLen(progLenA),
      .progReady(progReadyA), .errOverflow(errOverflowA), .errUnbalanced(errUnbalancedA)
   );

   bf_program_mem #(.ADDR_WIDTH(4), .NEST_WIDTH(6)) dutB (
      .clk(clk), .reset(reset), .loadStart(loadStart), .loadValid(loadValid),
      .loadData(loadData), .loadReady(loadReadyB), .loadEnd(loadEnd),
      .addrIn(addrIn[3:0]), .dataOut(dataOutB), .progLen(progLenB),
      .progReady(progReadyB), .errOverflow(errOverflowB), .errUnbalanced(errUnbalancedB)
   );

   localparam int NEST_MAX = 63;
   int         cap[2] = '{255, 15};
   int         mLen[2];
   int         mNest[2];
   bit         mOv[2];
   bit         mUnb[2];
   logic [7:0] mProg[2][256];
   int         phase;  // 0 idle, 1 loading, 2 terminating, 3 program valid
   logic [7:0] cmds[8] = '{8'h2B, 8'h2D, 8'h3C, 8'h3E, 8'h2E, 8'h2C, 8'h5B, 8'h5D};

   function automatic bit isCmd(input logic [7:0] b);
      return b inside {8'h2B, 8'h2D, 8'h3C, 8'h3E, 8'h2E, 8'h2C, 8'h5B, 8'h5D};
   endfunction

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      nChecks++;
      if (got !== exp) begin
         nErrors++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic modelReset(input int newPhase);
      for (int i = 0; i < 2; i++) begin
         mLen[i]  = 0;
         mNest[i] = 0;
         mOv[i]   = 1'b0;
         mUnb[i]  = 1'b0;
      end
      phase = newPhase;
   endtask

   task automatic modelByte(input logic [7:0] b);
      if (!isCmd(b)) return;
      for (int i = 0; i < 2; i++) begin
         if (mLen[i] < cap[i]) begin
            mProg[i][mLen[i]] = b;
            mLen[i]++;
         end else begin
            mOv[i] = 1'b1;
         end
         if (b == 8'h5B) begin
            if (mNest[i] == NEST_MAX) mUnb[i] = 1'b1;
            else mNest[i]++;
         end else if (b == 8'h5D) begin
            if (mNest[i] == 0) mUnb[i] = 1'b1;
            else mNest[i]--;
         end
      end
   endtask

   task automatic checkOutputs(input logic [7:0] expA, input logic [7:0] expB);
      check("A.dataOut",       32'(dataOutA),       32'(expA));
      check("A.progLen",       32'(progLenA),       32'(mLen[0]));
      check("A.progReady",     32'(progReadyA),     32'(phase == 3));
      check("A.loadReady",     32'(loadReadyA),     32'(phase == 1));
      check("A.errOverflow",   32'(errOverflowA),   32'(mOv[0]));
      check("A.errUnbalanced", 32'(errUnbalancedA), 32'(mUnb[0]));
      check("B.dataOut",       32'(dataOutB),       32'(expB));
      check("B.progLen",       32'(progLenB),       32'(mLen[1]));
      check("B.progReady",     32'(progReadyB),     32'(phase == 3));
      check("B.loadReady",     32'(loadReadyB),     32'(phase == 1));
      check("B.errOverflow",   32'(errOverflowB),   32'(mOv[1]));
      check("B.errUnbalanced", 32'(errUnbalancedB), 32'(mUnb[1]));
   endtask

   function automatic logic [7:0] randAddr();
      if ($urandom_range(0, 3) == 0) return 8'($urandom);
      return 8'($urandom_range(0, 20));
   endfunction

   // One clock of stimulus; the model advances by the same transaction and all outputs are compared.
   task automatic cycle(input bit start, input bit valid, input logic [7:0] data,
                        input bit fin, input logic [7:0] addr);
      logic [7:0] expA, expB;
      int aB;
      loadStart = start;
      loadValid = valid;
      loadData  = data;
      loadEnd   = fin;
      addrIn    = addr;
      aB   = int'(addr) % 16;
      expA = (phase == 3 && int'(addr) < mLen[0]) ? mProg[0][addr] : 8'h00;
      expB = (phase == 3 && aB < mLen[1]) ? mProg[1][aB] : 8'h00;
      @(posedge clk);
      #1;
      loadStart = 1'b0;
      loadValid = 1'b0;
      loadEnd   = 1'b0;
      if (start) begin
         modelReset(1);
      end else if (phase == 2) begin
         for (int i = 0; i < 2; i++)
            if (mNest[i] != 0) mUnb[i] = 1'b1;
         phase = 3;
      end else if (phase == 1) begin
         if (valid) modelByte(data);
         if (fin) phase = 2;
      end
      checkOutputs(expA, expB);
   endtask

   task automatic sendStr(input string s, input bit gaps);
      for (int k = 0; k < s.len(); k++) begin
         if (gaps && (k % 2 == 1))
            cycle(1'b0, 1'b0, 8'($urandom), 1'b0, randAddr());
         cycle(1'b0, 1'b1, s[k], 1'b0, randAddr());
      end
   endtask

   task automatic endAndRun();
      cycle(1'b0, 1'b0, 8'h00, 1'b1, randAddr());
      cycle(1'b0, 1'b0, 8'h00, 1'b0, randAddr());
   endtask

   task automatic readA(input string tag, input logic [7:0] addr, input logic [7:0] exp);
      cycle(1'b0, 1'b0, 8'h00, 1'b0, addr);
      check(tag, 32'(dataOutA), 32'(exp));
   endtask

   initial begin
      logic [7:0] rdExp[5];
      logic [7:0] rdAddr[5];
      reset     = 1'b1;
      loadStart = 1'b0;
      loadValid = 1'b0;
      loadEnd   = 1'b0;
      loadData  = 8'h00;
      addrIn    = 8'h00;
      modelReset(0);
      repeat (2) @(posedge clk);
      #1;
      checkOutputs(8'h00, 8'h00);
      @(negedge clk);
      reset = 1'b0;

      // Basic program, then directed reads including terminator and past-end.
      cycle(1'b1, 1'b0, 8'h00, 1'b0, 8'h00);
      sendStr("+[.+]>-[.-]", 1'b0);
      endAndRun();
      check("t1.progLen", 32'(progLenA), 32'd11);
      check("t1.progReady", 32'(progReadyA), 32'd1);
      check("t1.errs", 32'({errOverflowA, errUnbalancedA}), 32'd0);
      rdAddr = '{8'd0, 8'd1, 8'd10, 8'd11, 8'd12};
      rdExp  = '{8'h2B, 8'h5B, 8'h5D, 8'h00, 8'h00};
      for (int i = 0; i < 5; i++) readA("t1.read", rdAddr[i], rdExp[i]);

      // Non-command characters dropped, loadValid toggling.
      cycle(1'b1, 1'b0, 8'h00, 1'b0, 8'h00);
      sendStr("+ a\n[-]", 1'b1);
      endAndRun();
      check("t2.progLen", 32'(progLenA), 32'd4);
      rdExp = '{8'h2B, 8'h5B, 8'h2D, 8'h5D, 8'h00};
      for (int i = 0; i < 5; i++) readA("t2.read", 8'(i), rdExp[i]);

      // Unmatched ']' then unclosed brackets; loadStart clears the error.
      cycle(1'b1, 1'b0, 8'h00, 1'b0, 8'h00);
      sendStr("]", 1'b0);
      check("t3.unbAfterClose", 32'(errUnbalancedA), 32'd1);
      sendStr("[[", 1'b0);
      endAndRun();
      check("t3.unbRun", 32'(errUnbalancedA), 32'd1);
      check("t3.progLen", 32'(progLenA), 32'd3);
      cycle(1'b1, 1'b0, 8'h00, 1'b0, 8'h00);
      check("t3.unbCleared", 32'(errUnbalancedA), 32'd0);
      check("t3.readyCleared", 32'(progReadyA), 32'd0);

      // Small instance overflows at 15 bytes; terminator lands in the last slot.
      for (int i = 0; i < 17; i++) cycle(1'b0, 1'b1, 8'h2B, 1'b0, randAddr());
      endAndRun();
      check("t4.progLenB", 32'(progLenB), 32'd15);
      check("t4.ovB", 32'(errOverflowB), 32'd1);
      check("t4.ovA", 32'(errOverflowA), 32'd0);
      cycle(1'b0, 1'b0, 8'h00, 1'b0, 8'd15);
      check("t4.readB15", 32'(dataOutB), 32'd0);
      check("t4.readA15", 32'(dataOutA), 32'h2B);

      // Byte with loadStart discarded; loadStart beats loadEnd; large-instance overflow; nest overflow.
      cycle(1'b1, 1'b1, 8'h2B, 1'b0, 8'h00);
      cycle(1'b1, 1'b0, 8'h00, 1'b1, 8'h00);
      for (int i = 0; i < 260; i++) cycle(1'b0, 1'b1, 8'h3E, 1'b0, randAddr());
      cycle(1'b0, 1'b1, 8'h2E, 1'b1, randAddr());
      cycle(1'b0, 1'b0, 8'h00, 1'b0, 8'd255);
      cycle(1'b0, 1'b0, 8'h00, 1'b0, 8'd254);
      cycle(1'b1, 1'b0, 8'h00, 1'b0, 8'h00);
      for (int i = 0; i < 66; i++) cycle(1'b0, 1'b1, 8'h5B, 1'b0, randAddr());
      for (int i = 0; i < 63; i++) cycle(1'b0, 1'b1, 8'h5D, 1'b0, randAddr());
      endAndRun();
      cycle(1'b0, 1'b0, 8'h00, 1'b1, randAddr());

      // Reset mid-load acts without a clock edge; a lone loadEnd afterwards is ignored.
      cycle(1'b1, 1'b0, 8'h00, 1'b0, 8'h00);
      sendStr("+-<>.", 1'b0);
      @(negedge clk);
      reset = 1'b1;
      #1;
      check("t5.rstProgLen", 32'(progLenA), 32'd0);
      check("t5.rstLoadReady", 32'(loadReadyA), 32'd0);
      check("t5.rstReady", 32'(progReadyA), 32'd0);
      check("t5.rstDataOut", 32'(dataOutA), 32'd0);
      check("t5.rstErrs", 32'({errOverflowA, errUnbalancedA}), 32'd0);
      modelReset(0);
      @(negedge clk);
      reset = 1'b0;
      cycle(1'b0, 1'b0, 8'h00, 1'b1, 8'h00);
      cycle(1'b0, 1'b0, 8'h00, 1'b0, 8'h00);
      check("t5.idleReady", 32'(progReadyA), 32'd0);

      // Random programs with gaps, junk bytes and occasional loadEnd on the last byte.
      for (int p = 0; p < 40; p++) begin
         int n;
         logic [7:0] b;
         cycle(1'b1, 1'($urandom_range(0, 1)), 8'($urandom), 1'($urandom_range(0, 1)), randAddr());
         n = $urandom_range(0, 40);
         for (int k = 0; k < n; k++) begin
            if ($urandom_range(0, 3) == 0)
               cycle(1'b0, 1'b0, 8'($urandom), 1'b0, randAddr());
            if ($urandom_range(0, 9) < 7) b = cmds[$urandom_range(0, 7)];
            else b = 8'($urandom);
            cycle(1'b0, 1'b1, b, (k == n - 1) && ($urandom_range(0, 1) == 1), randAddr());
         end
         if (phase == 1) cycle(1'b0, 1'b0, 8'h00, 1'b1, randAddr());
         for (int k = 0; k < 12; k++)
            cycle(1'b0, 1'($urandom_range(0, 1)), 8'($urandom), 1'($urandom_range(0, 5) == 0), randAddr());
      end

      $display("Simulation finished: %0d checks, %0d errors", nChecks, nErrors);
      $finish;
   end
endmodule
